// File: rtl/mips_vga_pkg.sv
// Shared definitions for the MIPS VGA debug overlay: register-dump FSM states
// and the default register-file geometry.
package mips_vga_pkg;

    localparam int NLOC_DEFAULT  = 32;
    localparam int DBITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks the register file through a spare read port and streams each
// (index, value) pair to a valid/ready consumer, then pulses done.
module regfile_dumper
    import mips_vga_pkg::*;
#(
    parameter int Nloc  = NLOC_DEFAULT,
    parameter int Dbits = DBITS_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    grant,
    output logic [Dbits-1:0]        rd_addr,
    input  logic [Dbits-1:0]        rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(Nloc)-1:0] out_index,
    output logic [Dbits-1:0]        out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int            IW   = $clog2(Nloc);
    localparam logic [IW-1:0] LAST = IW'(Nloc - 1);

    dump_state_t      r_state;
    dump_state_t      w_next;
    logic [IW-1:0]    r_cnt;
    logic [IW-1:0]    r_index;
    logic [Dbits-1:0] r_data;
    logic             w_last;
    logic             w_hs;

    assign w_last    = (r_cnt == LAST);
    assign w_hs      = (r_state == ST_SEND) && out_ready;
    assign rd_addr   = Dbits'(r_cnt);
    assign out_index = r_index;
    assign out_data  = r_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_READ;
            ST_READ: if (grant) w_next = ST_SEND;
            ST_SEND: if (w_hs)  w_next = w_last ? ST_DONE : ST_READ;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_SEND);
        done      = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
    end

    // Counter is parked at 0 outside a dump so rd_addr reads 0 while idle;
    // the terminal test happens before any increment, so it never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_index <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) r_cnt <= '0;
                ST_READ: begin
                    if (grant) begin
                        r_data  <= rd_data;
                        r_index <= r_cnt;
                    end
                end
                ST_SEND: if (w_hs && !w_last) r_cnt <= r_cnt + 1'b1;
                ST_DONE: r_cnt <= '0;
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 Parameter Nloc, default 32: number of registers scanned.
REQ-002 Parameter Dbits, default 32: data width and address width of the register-file read port.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse requesting a full dump; ignored unless idle.
REQ-006 grant  input  1  read port granted to dumper this cycle (CPU not using it).
REQ-007 rd_addr  output  Dbits  read address driven to the register-file read port.
REQ-008 rd_data  input  Dbits  combinational read data returned for rd_addr.
REQ-009 out_valid  output  1  out_index/out_data hold a valid entry.
REQ-010 out_ready  input  1  consumer (VGA text overlay) accepts the entry.
REQ-011 out_index  output  $clog2(Nloc)  register number of the current entry.
REQ-012 out_data  output  Dbits  captured register value.
REQ-013 busy  output  1  high from accepted start until the DONE cycle, inclusive.
REQ-014 done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-015 States: IDLE, READ, SEND, DONE.
REQ-016 IDLE: start=1 -> READ, index counter cleared to 0; otherwise stay.
REQ-017 READ: rd_addr = counter (zero-extended); when grant=1, rd_data is captured into out_data, counter into out_index, -> SEND; grant=0 -> stay in READ, nothing captured.
REQ-018 SEND: out_valid=1; out_index/out_data stable until the handshake completes.
REQ-019 Handshake completes on a cycle with out_valid=1 and out_ready=1; out_ready may be high before out_valid.
REQ-020 SEND on handshake: counter = Nloc-1 -> DONE; else counter increments, -> READ.
REQ-021 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-022 Minimum per-entry cost is 2 cycles (READ with grant, SEND with ready); a full dump with grant and out_ready held high takes 2*Nloc cycles plus 1 DONE cycle.
REQ-023 Entry 0 is emitted with whatever rd_data returns; the dumper does not special-case register 0.
REQ-024 rd_addr holds the current counter in every state; in IDLE it is 0.
REQ-025 start while busy is ignored; it does not restart or extend the dump.
REQ-026 Counter width $clog2(Nloc); no wrap occurs because the terminal check precedes the increment.
REQ-027 out_valid is never high outside SEND; done is never high outside DONE.

Reset
REQ-028 reset_n=0 forces, asynchronously: state IDLE, counter 0, out_valid 0, out_index 0, out_data 0, busy 0, done 0, rd_addr 0.
REQ-029 Reset asserted mid-dump abandons the dump; no done pulse; after release the block waits for a new start.

Structure
REQ-030 The state enum (IDLE, READ, SEND, DONE) is declared in shared package mips_vga_pkg, alongside the Nloc/Dbits defaults.
REQ-031 Single module, no sub-modules; counter and FSM are local.

Verification
REQ-032 Regfile preloaded with rf[i] = 32'h1000_0000+i, grant=1, out_ready=1, start pulse -> 32 entries in order (index 0 value 0, index 5 value 32'h1000_0005, index 31 value 32'h1000_001F), done at cycle 65 after start, busy falls with done.
REQ-033 grant low for 3 cycles during READ of index 7 -> no capture, rd_addr held at 7, entry 7 emitted after grant returns with correct value.
REQ-034 out_ready low for 4 cycles while entry 12 is valid -> out_valid, out_index=12, out_data stable throughout; no entry skipped or duplicated.
REQ-035 Second start pulse at entry 10 -> ignored; exactly 32 entries and one done pulse.
REQ-036 reset_n low asynchronously at entry 20 -> all outputs 0 immediately, no done; fresh start afterwards dumps from index 0.
REQ-037 Nloc=8 build -> 8 entries, done after 17 cycles with grant and out_ready held high.
